// File: rtl/word_narrow_tx_if.sv
// Handshake bundle for the 32-to-16 narrowing transmitter: word input side and beat output side.
// The master modport is the transmitter itself; slave is the surrounding environment.
interface word_narrow_tx_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             out_short;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_short
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_short
  );
endinterface

// File: rtl/word_narrow_tx.sv
// Splits 32-bit words into 16-bit beats, sending sign-extension-only words as one compressed beat.
// Only IN_W == 2*OUT_W is supported.
module word_narrow_tx #(
  parameter int IN_W     = 32,
  parameter int OUT_W    = 16,
  parameter int COMPRESS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  word_narrow_tx_if.master bus,
  output logic        busy,
  output logic [15:0] words_sent,
  output logic [15:0] short_sent
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] hi_half;
  logic [OUT_W-1:0] beat_data;
  logic             beat_valid;
  logic             beat_last;
  logic             beat_short;

  logic             beat_done;
  logic             word_done;
  logic             accept;
  logic             fits;

  assign beat_done = beat_valid && bus.out_ready;
  assign word_done = beat_done && beat_last;

  // Finishing the last beat frees the slot in the same cycle, so words stream without bubbles.
  assign bus.in_ready = (state == IDLE) || word_done;
  assign accept       = bus.in_valid && bus.in_ready;
  assign fits         = (COMPRESS != 0) &&
                        (bus.in_data[IN_W-1:OUT_W] == {OUT_W{bus.in_data[OUT_W-1]}});

  assign bus.out_valid = beat_valid;
  assign bus.out_data  = beat_data;
  assign bus.out_last  = beat_last;
  assign bus.out_short = beat_short;
  assign busy          = beat_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hi_half    <= '0;
      beat_data  <= '0;
      beat_valid <= 1'b0;
      beat_last  <= 1'b0;
      beat_short <= 1'b0;
      words_sent <= 16'd0;
      short_sent <= 16'd0;
    end else begin
      if (word_done) begin
        words_sent <= words_sent + 16'd1;
        if (beat_short) begin
          short_sent <= short_sent + 16'd1;
        end
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SEND_LO;
            hi_half    <= bus.in_data[IN_W-1:OUT_W];
            beat_data  <= bus.in_data[OUT_W-1:0];
            beat_valid <= 1'b1;
            beat_last  <= fits;
            beat_short <= fits;
          end
        end

        SEND_LO: begin
          if (beat_done && !beat_last) begin
            state      <= SEND_HI;
            beat_data  <= hi_half;
            beat_last  <= 1'b1;
            beat_short <= 1'b0;
          end else if (accept) begin
            state      <= SEND_LO;
            hi_half    <= bus.in_data[IN_W-1:OUT_W];
            beat_data  <= bus.in_data[OUT_W-1:0];
            beat_valid <= 1'b1;
            beat_last  <= fits;
            beat_short <= fits;
          end else if (beat_done) begin
            state      <= IDLE;
            beat_data  <= '0;
            beat_valid <= 1'b0;
            beat_last  <= 1'b0;
            beat_short <= 1'b0;
          end
        end

        SEND_HI: begin
          if (accept) begin
            state      <= SEND_LO;
            hi_half    <= bus.in_data[IN_W-1:OUT_W];
            beat_data  <= bus.in_data[OUT_W-1:0];
            beat_valid <= 1'b1;
            beat_last  <= fits;
            beat_short <= fits;
          end else if (beat_done) begin
            state      <= IDLE;
            beat_data  <= '0;
            beat_valid <= 1'b0;
            beat_last  <= 1'b0;
            beat_short <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          beat_valid <= 1'b0;
          beat_last  <= 1'b0;
          beat_short <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_narrow_tx.sv
// Bench for word_narrow_tx: directed scenarios plus random traffic against a beat-queue model,
// with one compressing instance and one COMPRESS=0 instance.
module tb_word_narrow_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  word_narrow_tx_if #(.IN_W(32), .OUT_W(16)) bus_c ();
  word_narrow_tx_if #(.IN_W(32), .OUT_W(16)) bus_n ();

  logic        busy_c, busy_n;
  logic [15:0] ws_c, ss_c, ws_n, ss_n;

  word_narrow_tx #(.IN_W(32), .OUT_W(16), .COMPRESS(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_c),
    .busy(busy_c), .words_sent(ws_c), .short_sent(ss_c)
  );

  word_narrow_tx #(.IN_W(32), .OUT_W(16), .COMPRESS(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .bus(bus_n),
    .busy(busy_n), .words_sent(ws_n), .short_sent(ss_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        shrt;
  } beat_t;

  // Per instance: pending beats, words awaiting reconstruction, expected counters.
  beat_t       exp_q [2][$];
  logic [31:0] sent_q[2][$];
  logic [15:0] exp_words[2];
  logic [15:0] exp_short[2];
  logic [15:0] rx_lo[2];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit fitsShort(input logic [31:0] w, input bit comp);
    int s;
    s = $signed(w);
    return comp && (s >= -32768) && (s <= 32767);
  endfunction

  task automatic modelAccept(input int k, input logic [31:0] w);
    if (fitsShort(w, k == 0)) begin
      exp_q[k].push_back('{data: w[15:0], last: 1'b1, shrt: 1'b1});
    end else begin
      exp_q[k].push_back('{data: w[15:0], last: 1'b0, shrt: 1'b0});
      exp_q[k].push_back('{data: w[31:16], last: 1'b1, shrt: 1'b0});
    end
    sent_q[k].push_back(w);
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      sent_q[k].delete();
      exp_words[k] = 16'd0;
      exp_short[k] = 16'd0;
      rx_lo[k]     = 16'd0;
    end
  endtask

  // One clock cycle on instance k; the other instance sees no traffic and a stalled output.
  task automatic applyStimulus(input int k, input logic v, input logic [31:0] d, input logic r);
    logic        ov, ir, ol, os, bz;
    logic [15:0] od, ws, ss;
    logic [31:0] rec;
    beat_t       b;
    bus_c.in_valid  = (k == 0) ? v : 1'b0;
    bus_c.in_data   = (k == 0) ? d : 32'd0;
    bus_c.out_ready = (k == 0) ? r : 1'b0;
    bus_n.in_valid  = (k == 1) ? v : 1'b0;
    bus_n.in_data   = (k == 1) ? d : 32'd0;
    bus_n.out_ready = (k == 1) ? r : 1'b0;
    #1;
    if (k == 0) begin
      ov = bus_c.out_valid; ir = bus_c.in_ready; od = bus_c.out_data;
      ol = bus_c.out_last;  os = bus_c.out_short; bz = busy_c; ws = ws_c; ss = ss_c;
    end else begin
      ov = bus_n.out_valid; ir = bus_n.in_ready; od = bus_n.out_data;
      ol = bus_n.out_last;  os = bus_n.out_short; bz = busy_n; ws = ws_n; ss = ss_n;
    end
    checkOutput("out_valid", ov, exp_q[k].size() != 0);
    checkOutput("busy", bz, exp_q[k].size() != 0);
    checkOutput("in_ready", ir, (exp_q[k].size() == 0) || (r && exp_q[k].size() == 1));
    checkOutput("words_sent", ws, exp_words[k]);
    checkOutput("short_sent", ss, exp_short[k]);
    if (exp_q[k].size() != 0) begin
      b = exp_q[k][0];
      checkOutput("out_data", od, b.data);
      checkOutput("out_last", ol, b.last);
      checkOutput("out_short", os, b.shrt);
    end
    if (ov && r && exp_q[k].size() != 0) begin
      b = exp_q[k].pop_front();
      if (b.last) begin
        exp_words[k] = exp_words[k] + 16'd1;
        if (b.shrt) exp_short[k] = exp_short[k] + 16'd1;
        rec = os ? {{16{od[15]}}, od} : {od, rx_lo[k]};
        checkOutput("rx_word", rec, sent_q[k].pop_front());
      end else begin
        rx_lo[k] = od;
      end
    end
    if (v && ir) modelAccept(k, d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [15:0] h;
    int          k;
    modelReset();
    bus_c.in_valid = 1'b0; bus_c.in_data = 32'd0; bus_c.out_ready = 1'b0;
    bus_n.in_valid = 1'b0; bus_n.in_data = 32'd0; bus_n.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", bus_c.out_valid, 1'b0);
    checkOutput("rst_out_data", bus_c.out_data, 16'd0);
    checkOutput("rst_out_last", bus_c.out_last, 1'b0);
    checkOutput("rst_out_short", bus_c.out_short, 1'b0);
    checkOutput("rst_busy", busy_c, 1'b0);
    checkOutput("rst_words", ws_c, 16'd0);
    checkOutput("rst_short", ss_c, 16'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] compressed words");
    applyStimulus(0, 1'b1, 32'h0000_1234, 1'b1);
    applyStimulus(0, 1'b0, 32'd0, 1'b1);
    checkOutput("first_words", ws_c, 16'd1);
    checkOutput("first_short", ss_c, 16'd1);
    applyStimulus(0, 1'b1, 32'hFFFF_F234, 1'b1);
    applyStimulus(0, 1'b0, 32'd0, 1'b1);

    $display("[TB] boundary word 0x00008000");
    applyStimulus(0, 1'b1, 32'h0000_8000, 1'b1);
    applyStimulus(0, 1'b0, 32'd0, 1'b1);
    applyStimulus(0, 1'b0, 32'd0, 1'b1);
    checkOutput("boundary_short", ss_c, 16'd2);
    checkOutput("boundary_words", ws_c, 16'd3);

    $display("[TB] stall");
    applyStimulus(0, 1'b1, 32'h1234_5678, 1'b0);
    repeat (3) applyStimulus(0, 1'b1, 32'h0000_0055, 1'b0);
    applyStimulus(0, 1'b1, 32'h0000_0055, 1'b1);
    applyStimulus(0, 1'b1, 32'h0000_0055, 1'b1);
    applyStimulus(0, 1'b0, 32'd0, 1'b1);

    $display("[TB] back-to-back");
    applyStimulus(0, 1'b1, 32'h0000_0001, 1'b1);
    applyStimulus(0, 1'b1, 32'h0000_0002, 1'b1);
    applyStimulus(0, 1'b1, 32'h0000_0003, 1'b1);
    applyStimulus(0, 1'b0, 32'd0, 1'b1);

    $display("[TB] no compression instance");
    applyStimulus(1, 1'b1, 32'h0000_0001, 1'b1);
    applyStimulus(1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1, 1'b0, 32'd0, 1'b1);
    checkOutput("nc_short", ss_n, 16'd0);

    $display("[TB] reset during high beat");
    applyStimulus(0, 1'b1, 32'hABCD_1234, 1'b1);
    applyStimulus(0, 1'b0, 32'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", bus_c.out_valid, 1'b0);
    checkOutput("midrst_busy", busy_c, 1'b0);
    checkOutput("midrst_words", ws_c, 16'd0);
    checkOutput("midrst_short", ss_c, 16'd0);
    checkOutput("midrst_nc_words", ws_n, 16'd0);
    modelReset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b1, 32'h0000_0007, 1'b1);
    applyStimulus(0, 1'b0, 32'd0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      k = (i < 400) ? 0 : 1;
      if ((i % 50) > 44) k = 1 - k;
      case ($urandom_range(0, 3))
        0: begin h = 16'($urandom); d = {{16{h[15]}}, h}; end
        1: d = ($urandom_range(0, 1) != 0) ? 32'h0000_8000 : 32'hFFFF_7FFF;
        2: d = ($urandom_range(0, 1) != 0) ? 32'h0000_7FFF : 32'hFFFF_8000;
        default: d = $urandom;
      endcase
      applyStimulus(k, $urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0);
    end

    for (int j = 0; j < 2; j++) begin
      for (int n = 0; n < 8 && exp_q[j].size() != 0; n++) begin
        applyStimulus(j, 1'b0, 32'd0, 1'b1);
      end
      checkOutput("drain_empty", exp_q[j].size(), 32'd0);
      applyStimulus(j, 1'b0, 32'd0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
